div_issue_ctrl: RTL and testbench

//  EX-stage initiator for the multi-cycle DIV unit. Accepts DIV/DIVU from EX and drives the divider's start/annul handshake.

---
 rtl/div_issue_ctrl_pkg.sv | 20 ++
 rtl/div_issue_ctrl_if.sv | 23 ++
 rtl/div_issue_ctrl.sv | 130 +++++++++++++
 tb/tb_div_issue_ctrl.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_issue_ctrl_pkg.sv
// Shared types and constants for the EX-stage divide issue controller.
// The optional divide-by-zero shortcut is selected with DIV_ZERO_BYPASS_EN.
package div_issue_ctrl_pkg;

    typedef enum logic [2:0] {
        DIV_CTL_IDLE  = 3'd0,
        DIV_CTL_ISSUE = 3'd1,
        DIV_CTL_WAIT  = 3'd2,
        DIV_CTL_DONE  = 3'd3,
        DIV_CTL_DRAIN = 3'd4
    } div_ctl_state_e;

    // Annul hold time after a flush; long enough for the divider's
    // DivByZero -> DivEnd -> ready path to finish.
    localparam int          DRAIN_CYCLES_DEF = 3;
    localparam logic        RST_ENABLE       = 1'b1;
    localparam logic [31:0] ZERO_WORD        = 32'h0000_0000;
    localparam logic        DIV_START        = 1'b1;

endpackage

// File: rtl/div_issue_ctrl_if.sv
// Controller <-> multi-cycle divider connection.
// Handshake: start is a one-cycle request with signed_div/op1/op2 held stable
// until ready; ready is a one-cycle pulse with result valid in that cycle only;
// annul aborts the operation and any ready seen while annul is high is stale.
interface div_issue_ctrl_if;
    logic        start;
    logic        annul;
    logic        signed_div;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [63:0] result;
    logic        ready;

    modport master (
        output start, annul, signed_div, op1, op2,
        input  result, ready
    );

    modport slave (
        input  start, annul, signed_div, op1, op2,
        output result, ready
    );
endinterface

// File: rtl/div_issue_ctrl.sv
// EX-stage DIV/DIVU initiator: issues to the divider, stalls until the result
// returns, writes {HI,LO}, and annuls/drains on flush. Option: DIV_ZERO_BYPASS_EN.
module div_issue_ctrl
    import div_issue_ctrl_pkg::*;
#(
    parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ex_div_req_i,
    input  logic                   ex_div_signed_i,
    input  logic [31:0]            ex_op1_i,
    input  logic [31:0]            ex_op2_i,
    input  logic                   flush_i,
    div_issue_ctrl_if.master       div,
    output logic                   stall_o,
    output logic                   hilo_we_o,
    output logic [31:0]            hi_o,
    output logic [31:0]            lo_o,
    output div_ctl_state_e         state_dbg
);

    localparam logic [1:0] DRAIN_LOAD = 2'(DRAIN_CYCLES - 1);

    div_ctl_state_e state, state_nxt;
    logic [1:0]     drain_cnt;
    logic           accept;
    logic           start_c;
    logic           annul_c;
    logic           capture;
    logic           zero_bypass;
    logic           sgn_q;
    logic [31:0]    op1_q, op2_q, hi_q, lo_q;

`ifdef DIV_ZERO_BYPASS_EN
    assign zero_bypass = (ex_op2_i == ZERO_WORD);
`else
    assign zero_bypass = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        start_c   = 1'b0;
        annul_c   = 1'b0;
        stall_o   = 1'b0;
        hilo_we_o = 1'b0;
        accept    = 1'b0;
        capture   = 1'b0;
        case (state)
            DIV_CTL_IDLE: begin
                // A flush in the same cycle kills the instruction in EX.
                if (ex_div_req_i && !flush_i) begin
                    accept    = 1'b1;
                    stall_o   = 1'b1;
                    state_nxt = zero_bypass ? DIV_CTL_DONE : DIV_CTL_ISSUE;
                end
            end
            DIV_CTL_ISSUE: begin
                stall_o = 1'b1;
                if (flush_i) begin
                    state_nxt = DIV_CTL_DRAIN;
                end else begin
                    start_c   = DIV_START;
                    state_nxt = DIV_CTL_WAIT;
                end
            end
            DIV_CTL_WAIT: begin
                stall_o = 1'b1;
                if (flush_i) begin
                    state_nxt = DIV_CTL_DRAIN;
                end else if (div.ready) begin
                    capture   = 1'b1;
                    state_nxt = DIV_CTL_DONE;
                end
            end
            DIV_CTL_DONE: begin
                hilo_we_o = !flush_i;
                state_nxt = DIV_CTL_IDLE;
            end
            DIV_CTL_DRAIN: begin
                annul_c = 1'b1;
                if (drain_cnt == 2'd0) begin
                    state_nxt = DIV_CTL_IDLE;
                end
            end
            default: state_nxt = DIV_CTL_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state     <= DIV_CTL_IDLE;
            drain_cnt <= 2'd0;
            sgn_q     <= 1'b0;
            op1_q     <= ZERO_WORD;
            op2_q     <= ZERO_WORD;
            hi_q      <= ZERO_WORD;
            lo_q      <= ZERO_WORD;
        end else begin
            state <= state_nxt;
            if (accept) begin
                sgn_q <= ex_div_signed_i;
                op1_q <= ex_op1_i;
                op2_q <= ex_op2_i;
            end
            if (state_nxt == DIV_CTL_DRAIN && state != DIV_CTL_DRAIN) begin
                drain_cnt <= DRAIN_LOAD;
            end else if (state == DIV_CTL_DRAIN && drain_cnt != 2'd0) begin
                drain_cnt <= drain_cnt - 2'd1;
            end
            if (capture) begin
                hi_q <= div.result[63:32];
                lo_q <= div.result[31:0];
            end else if (accept && zero_bypass) begin
                hi_q <= ZERO_WORD;
                lo_q <= ZERO_WORD;
            end
        end
    end

    assign div.start      = start_c;
    assign div.annul      = annul_c;
    assign div.signed_div = sgn_q;
    assign div.op1        = op1_q;
    assign div.op2        = op2_q;
    assign hi_o           = hi_q;
    assign lo_o           = lo_q;
    assign state_dbg      = state;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Self-checking bench for div_issue_ctrl: timestamp-based reference model,
// a behavioural divider, directed cases plus randomized operations.
module tb_div_issue_ctrl;
    import div_issue_ctrl_pkg::*;

    localparam int DRAIN = DRAIN_CYCLES_DEF;

    logic        clk = 1'b0;
    logic        rst, req, sgn, flush;
    logic [31:0] op1, op2;
    logic        stall, hilo_we;
    logic [31:0] hi, lo;
    div_ctl_state_e state_dbg;

    div_issue_ctrl_if dif();

    div_issue_ctrl #(.DRAIN_CYCLES(DRAIN)) dut (
        .clk(clk), .rst(rst),
        .ex_div_req_i(req), .ex_div_signed_i(sgn),
        .ex_op1_i(op1), .ex_op2_i(op2), .flush_i(flush),
        .div(dif),
        .stall_o(stall), .hilo_we_o(hilo_we),
        .hi_o(hi), .lo_o(lo), .state_dbg(state_dbg)
    );

    // ---------------- clock / reset / cycle count ----------------
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h want %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        logic [31:0] q, r;
        if (b == 32'd0) return 64'd0;
        if (s) begin
            sa = $signed(a);
            sb = $signed(b);
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    // ---------------- behavioural divider ----------------
    int          rdy_at = -1;
    logic [63:0] rdy_res;

    always @(negedge clk) begin
        if (rst) begin
            rdy_at = -1;
        end else if (dif.start) begin
            rdy_at  = cyc + ((dif.op2 == 32'd0) ? 3 : 35);
            rdy_res = ref_div(dif.signed_div, dif.op1, dif.op2);
        end else if (dif.annul && rdy_at > cyc) begin
            // Sometimes let a late ready escape into the drain window.
            if ($urandom_range(1) == 1) begin
                rdy_at  = cyc + 1;
                rdy_res = {$urandom, $urandom};
            end else begin
                rdy_at = -1;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        dif.ready  = (rdy_at == cyc);
        dif.result = (rdy_at == cyc) ? rdy_res : {$urandom, $urandom};
    end

    // ---------------- reference model + compare ----------------
    // The model tracks the in-flight op by timestamps: acceptance cycle,
    // ready cycle, and the last cycle of the annul window.
    int          m_acc = -1, m_rdy = -1, m_drain_end = -1;
    logic        m_sgn;
    logic [31:0] m_op1, m_op2, m_hi, m_lo;
    logic [63:0] exp_q[$];
    int          first_stall = -1, we_cyc = -1, start_cyc = -1, annul_cnt = 0;

    always @(negedge clk) begin
        logic done_c, issue_c, wait_c, drain_c, idle_c;
        if (rst) begin
            m_acc = -1; m_rdy = -1; m_drain_end = -1;
            m_sgn = 1'b0; m_op1 = '0; m_op2 = '0; m_hi = '0; m_lo = '0;
            exp_q.delete();
        end else begin
            done_c  = (m_rdy >= 0) && (cyc == m_rdy + 1);
            issue_c = !done_c && (m_acc >= 0) && (m_rdy < 0) && (cyc == m_acc + 1);
            wait_c  = (m_acc >= 0) && (m_rdy < 0) && (cyc > m_acc + 1);
            drain_c = (cyc <= m_drain_end);
            idle_c  = !done_c && !issue_c && !wait_c && !drain_c;

            chk("start",   64'(dif.start), 64'(issue_c && !flush));
            chk("annul",   64'(dif.annul), 64'(drain_c));
            chk("stall",   64'(stall),     64'(issue_c || wait_c || (idle_c && req && !flush)));
            chk("hilo_we", 64'(hilo_we),   64'(done_c && !flush));
            chk("hi",      64'(hi),        64'(m_hi));
            chk("lo",      64'(lo),        64'(m_lo));
            chk("div_signed", 64'(dif.signed_div), 64'(m_sgn));
            chk("div_op1", 64'(dif.op1), 64'(m_op1));
            chk("div_op2", 64'(dif.op2), 64'(m_op2));
            if (dif.ready)
                chk("ready_window", 64'(state_dbg == DIV_CTL_WAIT || state_dbg == DIV_CTL_DRAIN), 64'd1);

            if (stall && first_stall < 0) first_stall = cyc;
            if (hilo_we) we_cyc = cyc;
            if (dif.start) start_cyc = cyc;
            if (dif.annul) annul_cnt++;

            if (idle_c && req && !flush) begin
                m_acc = cyc; m_rdy = -1;
                m_sgn = sgn; m_op1 = op1; m_op2 = op2;
                exp_q.push_back(ref_div(sgn, op1, op2));
`ifdef DIV_ZERO_BYPASS_EN
                if (op2 == 32'd0) begin
                    m_rdy = cyc; m_hi = '0; m_lo = '0;
                end
`endif
            end else if ((issue_c || wait_c) && flush) begin
                m_acc = -1;
                m_drain_end = cyc + DRAIN;
                if (exp_q.size() > 0) void'(exp_q.pop_front());
            end else if (wait_c && dif.ready) begin
                m_rdy = cyc;
                if (exp_q.size() > 0) {m_hi, m_lo} = exp_q[0];
            end else if (done_c) begin
                m_acc = -1; m_rdy = -1;
                if (exp_q.size() > 0) void'(exp_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks (entered/left at posedge+1) ----------------
    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    // Offsets are relative to T, the issue cycle (one after acceptance).
    task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                          input int flush_off, input int rst_off);
        logic fin;
        fin = 1'b0;
        first_stall = -1; we_cyc = -1; start_cyc = -1;
        req = 1'b1; sgn = s; op1 = a; op2 = b; flush = 1'b0;
        for (int k = 0; k < 120 && !fin; k++) begin
            @(negedge clk); #1;
            if (we_cyc >= 0 || flush || rst) begin
                fin = 1'b1;
            end else begin
                @(posedge clk); #1;
                flush = (first_stall >= 0) && (flush_off >= 0) && (cyc == first_stall + 1 + flush_off);
                if ((first_stall >= 0) && (rst_off >= 0) && (cyc == first_stall + 1 + rst_off)) begin
                    rst = 1'b1;
                    req = 1'b0;
                end
            end
        end
        if (!fin) chk("op_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        req = 1'b0; flush = 1'b0; rst = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        @(negedge clk); #1;
        chk({tag, "_stall"},   64'(stall),          64'd0);
        chk({tag, "_start"},   64'(dif.start),      64'd0);
        chk({tag, "_annul"},   64'(dif.annul),      64'd0);
        chk({tag, "_hilo_we"}, 64'(hilo_we),        64'd0);
        chk({tag, "_hilo"},    {hi, lo},            64'd0);
        chk({tag, "_ops"},     {dif.op1, dif.op2},  64'd0);
        chk({tag, "_signed"},  64'(dif.signed_div), 64'd0);
        @(posedge clk); #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int t0, we0;
        logic        rs;
        logic [31:0] ra, rb;
        int          fo, ro;

        rst = 1'b1; req = 1'b0; sgn = 1'b0; flush = 1'b0; op1 = '0; op2 = '0;
        dif.ready = 1'b0; dif.result = '0;
        idle_cycles(3);
        rst = 1'b0;
        chk_all_zero("reset");

        // DIVU 100/7: start at T, ready T+35, write at T+36.
        run_op(1'b0, 32'd100, 32'd7, -1, -1);
        chk("divu100_7_start_at_T", 64'(start_cyc), 64'(first_stall + 1));
        chk("divu100_7_we_latency", 64'(we_cyc - (first_stall + 1)), 64'd36);
        chk("divu100_7_hi", 64'(hi), 64'd2);
        chk("divu100_7_lo", 64'(lo), 64'd14);

        run_op(1'b1, 32'hFFFF_FFF9, 32'd2, -1, -1);
        chk("div_m7_2", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op(1'b1, 32'h8000_0000, 32'd1, -1, -1);
        chk("div_min_1", {hi, lo}, 64'h0000_0000_8000_0000);

        run_op(1'b0, 32'd5, 32'd0, -1, -1);
`ifdef DIV_ZERO_BYPASS_EN
        chk("divu5_0_no_start", 64'(start_cyc), 64'hFFFF_FFFF_FFFF_FFFF);
        chk("divu5_0_we_latency", 64'(we_cyc - first_stall), 64'd1);
`else
        chk("divu5_0_we_latency", 64'(we_cyc - (first_stall + 1)), 64'd4);
`endif
        chk("divu5_0_hilo", {hi, lo}, 64'd0);

        // Flush mid-divide, then a fresh op completes normally.
        annul_cnt = 0;
        run_op(1'b0, 32'd100, 32'd7, 10, -1);
        chk("flush10_no_we", 64'(we_cyc), 64'hFFFF_FFFF_FFFF_FFFF);
        run_op(1'b0, 32'd9, 32'd3, -1, -1);
        chk("flush10_annul_cycles", 64'(annul_cnt), 64'(DRAIN));
        chk("divu9_3", {hi, lo}, 64'h0000_0000_0000_0003);

        // Flush in the same cycle the divider reports ready.
        run_op(1'b0, 32'd100, 32'd7, 35, -1);
        chk("flush_at_ready_no_we", 64'(we_cyc), 64'hFFFF_FFFF_FFFF_FFFF);
        chk("flush_at_ready_hold", {hi, lo}, 64'h0000_0000_0000_0003);
        idle_cycles(DRAIN + 1);

        // Flush in DONE suppresses the write strobe.
        run_op(1'b0, 32'd50, 32'd7, 36, -1);
        chk("flush_done_no_we", 64'(we_cyc), 64'hFFFF_FFFF_FFFF_FFFF);

        // Back-to-back: second op accepted the cycle after DONE.
        run_op(1'b0, 32'd20, 32'd3, -1, -1);
        we0 = we_cyc;
        chk("b2b_first", {hi, lo}, 64'h0000_0002_0000_0006);
        run_op(1'b0, 32'd21, 32'd4, -1, -1);
        chk("b2b_accept_gap", 64'(first_stall - we0), 64'd1);
        chk("b2b_second", {hi, lo}, 64'h0000_0001_0000_0005);

        // Flush in IDLE beats the request.
        req = 1'b1; sgn = 1'b0; op1 = 32'd8; op2 = 32'd2; flush = 1'b1;
        @(negedge clk); #1;
        chk("idle_flush_no_stall", 64'(stall), 64'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        run_op(1'b0, 32'd8, 32'd2, -1, -1);
        chk("divu8_2", {hi, lo}, 64'h0000_0000_0000_0004);

        // Reset mid-divide.
        run_op(1'b0, 32'd100, 32'd7, -1, 20);
        chk("rst_mid_no_we", 64'(we_cyc), 64'hFFFF_FFFF_FFFF_FFFF);
        chk_all_zero("rst_mid");

        // Randomized operations.
        for (int n = 0; n < 60; n++) begin
            rs = 1'($urandom_range(1));
            ra = ($urandom_range(3) == 0) ? 32'($urandom_range(200)) : $urandom;
            case ($urandom_range(7))
                0:       rb = 32'd0;
                1, 2:    rb = 32'($urandom_range(15, 1));
                default: rb = $urandom;
            endcase
            if (rs && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF) rb = 32'd1;
            fo = ($urandom_range(9) < 3) ? int'($urandom_range(37)) : -1;
            ro = ($urandom_range(19) == 0) ? int'($urandom_range(36)) : -1;
            run_op(rs, ra, rb, fo, ro);
            t0 = int'($urandom_range(3));
            if (t0 == 3) begin
                flush = 1'b1;
                idle_cycles(1);
                flush = 1'b0;
            end else begin
                idle_cycles(t0);
            end
        end
        idle_cycles(DRAIN + 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
